// File: rtl/pe_norm_pipe.sv
// pe_norm_pipe: two-stage, multi-lane floating-point normaliser (leading-zero shift plus exponent adjust) behind one valid/ready handshake.
`ifndef MANTISSA
`define MANTISSA 23
`endif
`ifndef EXPONENT
`define EXPONENT 8
`endif
module pe_norm_pipe #(
  parameter int MANTISSA = `MANTISSA,
  parameter int EXPONENT = `EXPONENT,
  parameter int LANES = 4,
  parameter int CLAMP = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*(MANTISSA+1)-1:0]   in_significand,
  input  logic [LANES*EXPONENT-1:0]       in_exponent,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*(MANTISSA+1)-1:0]   out_significand,
  output logic [LANES*EXPONENT-1:0]       out_exponent,
  output logic [LANES-1:0]                out_zero,
  output logic [LANES-1:0]                out_underflow
);
  localparam int SW = MANTISSA + 1;
  localparam int LW = $clog2(MANTISSA + 2);
  localparam int CW = EXPONENT > LW ? EXPONENT : LW;
  function automatic logic [CW-1:0] lzc(input logic [SW-1:0] s);
    lzc = CW'(SW);
    for (int i = 0; i < SW; i++)
      if (s[i]) lzc = CW'(SW - 1 - i);
  endfunction
  logic                  s1_valid, s1_load, s2_load;
  logic [LANES*SW-1:0]   s1_sig, n_sig;
  logic [LANES*EXPONENT-1:0] s1_exp, n_exp;
  logic [LANES*CW-1:0]   s1_lz, in_lz;
  logic [LANES-1:0]      n_zero, n_uf;
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !rst && s1_load;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CW-1:0] e, lz, sh;
    logic z, u, c;
    assign in_lz[k*CW +: CW] = lzc(in_significand[k*SW +: SW]);
    always_comb begin
      e  = CW'(s1_exp[k*EXPONENT +: EXPONENT]);
      lz = s1_lz[k*CW +: CW];
      z  = s1_sig[k*SW +: SW] == '0;
      u  = !z && lz > e;
      c  = u && CLAMP != 0;
      // a clamped underflow stops shifting once the exponent reaches zero
      sh = c ? e : lz;
    end
    assign n_sig[k*SW +: SW] = z ? '0 : s1_sig[k*SW +: SW] << sh;
    assign n_exp[k*EXPONENT +: EXPONENT] = (z || c) ? '0 : EXPONENT'(e - lz);
    assign n_zero[k] = z;
    assign n_uf[k]   = u;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_sig          <= '0;
      s1_exp          <= '0;
      s1_lz           <= '0;
      out_valid       <= 1'b0;
      out_significand <= '0;
      out_exponent    <= '0;
      out_zero        <= '0;
      out_underflow   <= '0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s1_load && in_valid) begin
        s1_sig <= in_significand;
        s1_exp <= in_exponent;
        s1_lz  <= in_lz;
      end
      if (s2_load) out_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        out_significand <= n_sig;
        out_exponent    <= n_exp;
        out_zero        <= n_zero;
        out_underflow   <= n_uf;
      end
    end
  end
endmodule

// File: tb/tb_pe_norm_pipe.sv
// tb_pe_norm_pipe: directed-vector bench running a clamping and a wrapping normaliser side by side against a hand-computed table.
module tb_pe_norm_pipe;
  localparam int L = 4, SW = 24, E = 8, N = 12;
  typedef struct {
    logic [23:0] sig;
    logic [7:0]  ex;
    logic [23:0] sig1;
    logic [7:0]  ex1;
    logic [23:0] sig0;
    logic [7:0]  ex0;
    logic        z;
    logic        u;
  } vec_t;
  vec_t tbl [N];
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [L*SW-1:0] in_sig = '0;
  logic [L*E-1:0]  in_exp = '0;
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [L*SW-1:0] out_sig_a, out_sig_b;
  logic [L*E-1:0]  out_exp_a, out_exp_b;
  logic [L-1:0]    out_zero_a, out_zero_b, out_uf_a, out_uf_b;
  int total = 0, bad = 0, rx = 0, cyc = 0, cur_idx = 0;
  int q[$];
  pe_norm_pipe #(.MANTISSA(23), .EXPONENT(8), .LANES(L), .CLAMP(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_significand(in_sig), .in_exponent(in_exp),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_significand(out_sig_a), .out_exponent(out_exp_a),
    .out_zero(out_zero_a), .out_underflow(out_uf_a));
  pe_norm_pipe #(.MANTISSA(23), .EXPONENT(8), .LANES(L), .CLAMP(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_significand(in_sig), .in_exponent(in_exp),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_significand(out_sig_b), .out_exponent(out_exp_b),
    .out_zero(out_zero_b), .out_underflow(out_uf_b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  // scoreboard: lane k of beat idx carries table entry (idx+k)%N
  always @(negedge clk) if (!rst) begin
    if (out_valid_a && out_ready) begin
      if (q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
      else begin
        int idx;
        idx = q.pop_front();
        rx++;
        chk($sformatf("valid_b_beat%0d", idx), 64'(out_valid_b), 64'd1);
        for (int k = 0; k < L; k++) begin
          vec_t v;
          v = tbl[(idx + k) % N];
          chk($sformatf("clamp_v%0d_lane%0d", idx, k),
              {out_sig_a[k*SW +: SW], out_exp_a[k*E +: E], out_zero_a[k], out_uf_a[k]},
              {v.sig1, v.ex1, v.z, v.u});
          chk($sformatf("wrap_v%0d_lane%0d", idx, k),
              {out_sig_b[k*SW +: SW], out_exp_b[k*E +: E], out_zero_b[k], out_uf_b[k]},
              {v.sig0, v.ex0, v.z, v.u});
        end
      end
    end
    if (in_valid && in_ready_a) q.push_back(cur_idx);
  end
  task automatic drive(input int i);
    cur_idx = i;
    for (int k = 0; k < L; k++) begin
      in_sig[k*SW +: SW] = tbl[(i + k) % N].sig;
      in_exp[k*E +: E]   = tbl[(i + k) % N].ex;
    end
    in_valid = 1'b1;
  endtask
  task automatic send(input int i);
    logic ok;
    drive(i);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ok = in_ready_a;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    chk("send_timeout", 64'd0, 64'd1);
  endtask
  task automatic drain();
    for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask
  initial begin
    int start, rx0, s_sig, s_exp;
    tbl[0]  = '{24'h000001, 8'd100, 24'h800000, 8'd77,  24'h800000, 8'd77,  1'b0, 1'b0};
    tbl[1]  = '{24'h000000, 8'd55,  24'h000000, 8'd0,   24'h000000, 8'd0,   1'b1, 1'b0};
    tbl[2]  = '{24'h000100, 8'd10,  24'h040000, 8'd0,   24'h800000, 8'd251, 1'b0, 1'b1};
    tbl[3]  = '{24'h800000, 8'd0,   24'h800000, 8'd0,   24'h800000, 8'd0,   1'b0, 1'b0};
    tbl[4]  = '{24'h400000, 8'd1,   24'h800000, 8'd0,   24'h800000, 8'd0,   1'b0, 1'b0};
    tbl[5]  = '{24'h400000, 8'd0,   24'h400000, 8'd0,   24'h800000, 8'd255, 1'b0, 1'b1};
    tbl[6]  = '{24'h000001, 8'd0,   24'h000001, 8'd0,   24'h800000, 8'd233, 1'b0, 1'b1};
    tbl[7]  = '{24'h123456, 8'd200, 24'h91A2B0, 8'd197, 24'h91A2B0, 8'd197, 1'b0, 1'b0};
    tbl[8]  = '{24'h000000, 8'd0,   24'h000000, 8'd0,   24'h000000, 8'd0,   1'b1, 1'b0};
    tbl[9]  = '{24'h0000FF, 8'd255, 24'hFF0000, 8'd239, 24'hFF0000, 8'd239, 1'b0, 1'b0};
    tbl[10] = '{24'h00F000, 8'd8,   24'hF00000, 8'd0,   24'hF00000, 8'd0,   1'b0, 1'b0};
    tbl[11] = '{24'h00F000, 8'd7,   24'h780000, 8'd0,   24'hF00000, 8'd255, 1'b0, 1'b1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_a), 64'd0);
    chk("rst_out_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
    chk("rst_out_data", 64'(|{out_sig_a, out_exp_a, out_zero_a, out_uf_a}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready_a), 64'd1);
    // latency: driven in cycle c, visible in cycle c+2
    out_ready = 1'b1;
    @(posedge clk); #1 drive(0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("latency_c1_idle", 64'(out_valid_a), 64'd0);
    @(negedge clk);
    chk("latency_c2_valid", 64'(out_valid_a), 64'd1);
    drain();
    // full-rate stream of the whole table
    start = cyc;
    for (int i = 0; i < N; i++) send(i);
    chk("throughput_cycles", 64'(cyc - start), 64'(N));
    in_valid = 1'b0;
    drain();
    chk("table_count", 64'(rx), 64'(N + 1));
    // stall: two beats fill the pipe, outputs hold, then all six drain in order
    rx0 = rx;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send((i * 5) % N);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_in_ready_low", 64'(in_ready_a), 64'd0);
        s_sig = int'(out_sig_a[SW-1:0]);
        s_exp = int'(out_exp_a[E-1:0]);
        repeat (3) @(negedge clk);
        chk("stall_valid_held", 64'(out_valid_a), 64'd1);
        chk("stall_sig_stable", 64'(out_sig_a[SW-1:0]), 64'(s_sig));
        chk("stall_exp_stable", 64'(out_exp_a[E-1:0]), 64'(s_exp));
        chk("stall_in_ready_held", 64'(in_ready_a), 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", 64'(rx - rx0), 64'd6);
    // reset with two beats in flight: neither may emerge
    out_ready = 1'b0;
    send(3);
    send(7);
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    rx0 = rx;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready_a), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
    chk("midrst_out_data", 64'(|{out_sig_a, out_exp_a, out_zero_a, out_uf_a}), 64'd0);
    chk("midrst_in_ready_back", 64'(in_ready_a), 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_output", 64'(rx - rx0), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
